// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//   Shares one single-beat memory port between the fetch stage (instruction
//   requester) and the memory stage (data requester). One transaction runs at
//   a time: grant in IDLE, hold the request in REQ until accepted, wait for
//   the response in WAIT, then return the data to the owner.
//   Data requests have fixed priority. A starvation counter lets fetch win
//   after STARVE_LIMIT consecutive lost rounds. A fetch that is redirected
//   while it owns the port is drained: memory completes, no response returns.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   i_valid/i_addr      fetch request (held until i_data_ok or redirect)
//   i_data_ok/i_data    fetch response pulse and instruction word
//   d_valid..d_wdata    data request (held stable until d_data_ok)
//   d_data_ok/d_data    data response pulse and load data
//   m_valid..m_wdata    memory request, stable while m_valid && !m_ready
//   m_ready             memory accepts the request this cycle
//   m_data_ok/m_data    memory response, one cycle, only after acceptance
//   owner               debug: 0 none, 1 fetch, 2 data
module imem_dmem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_valid,
   input  logic [63:0] i_addr,
   output logic        i_data_ok,
   output logic [31:0] i_data,
   input  logic        d_valid,
   input  logic        d_write,
   input  logic [63:0] d_addr,
   input  logic [2:0]  d_size,
   input  logic [7:0]  d_strobe,
   input  logic [63:0] d_wdata,
   output logic        d_data_ok,
   output logic [63:0] d_data,
   output logic        m_valid,
   output logic        m_write,
   output logic [63:0] m_addr,
   output logic [2:0]  m_size,
   output logic [7:0]  m_strobe,
   output logic [63:0] m_wdata,
   input  logic        m_ready,
   input  logic        m_data_ok,
   input  logic [63:0] m_data,
   output logic [1:0]  owner
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

   localparam logic [1:0]       OWN_NONE = 2'd0;
   localparam logic [1:0]       OWN_I    = 2'd1;
   localparam logic [1:0]       OWN_D    = 2'd2;
   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);

   state_t           state_q, state_d;
   logic [1:0]       owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flush_q, flush_d;

   // Latched copy of the granted request; drives the memory side.
   logic             write_q;
   logic [63:0]      addr_q;
   logic [2:0]       size_q;
   logic [7:0]       strobe_q;
   logic [63:0]      wdata_q;

   logic grant_d, grant_i, complete, fetch_own, flush_now;

   // Data wins unless fetch has been starved; with fetch idle, data is never
   // blocked by a saturated counter.
   assign grant_d   = (state_q == IDLE) && d_valid && ((cnt_q < LIMIT) || !i_valid);
   assign grant_i   = (state_q == IDLE) && !grant_d && i_valid;
   assign fetch_own = (owner_q == OWN_I);
   // The fetch stage moved on (dropped or changed address) while it owns the port.
   assign flush_now = fetch_own && (!i_valid || (i_addr != addr_q));
   // Response accepted in WAIT, or in REQ when it coincides with acceptance.
   // Reset suppresses any response in the cycle it is asserted.
   assign complete  = !reset && m_data_ok &&
                      ((state_q == WAIT) || ((state_q == REQ) && m_ready));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= OWN_NONE;
         cnt_q   <= '0;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      flush_d = flush_q;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d = REQ;
               owner_d = OWN_D;
               if (i_valid && (cnt_q < LIMIT))
                  cnt_d = cnt_q + 1'b1;
            end else if (grant_i) begin
               state_d = REQ;
               owner_d = OWN_I;
               cnt_d   = '0;
            end
         end
         REQ, WAIT: begin
            if (flush_now)
               flush_d = 1'b1;
            if (complete) begin
               state_d = IDLE;
               owner_d = OWN_NONE;
               flush_d = 1'b0;
            end else if ((state_q == REQ) && m_ready) begin
               state_d = WAIT;
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = OWN_NONE;
            flush_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         write_q  <= 1'b0;
         addr_q   <= '0;
         size_q   <= '0;
         strobe_q <= '0;
         wdata_q  <= '0;
      end else if (grant_d) begin
         write_q  <= d_write;
         addr_q   <= d_addr;
         size_q   <= d_size;
         strobe_q <= d_strobe;
         wdata_q  <= d_wdata;
      end else if (grant_i) begin
         // Fetch is always a 4-byte read.
         write_q  <= 1'b0;
         addr_q   <= i_addr;
         size_q   <= 3'd2;
         strobe_q <= '0;
         wdata_q  <= '0;
      end
   end

   assign m_valid  = (state_q == REQ);
   assign m_write  = write_q;
   assign m_addr   = addr_q;
   assign m_size   = size_q;
   assign m_strobe = strobe_q;
   assign m_wdata  = wdata_q;
   assign owner    = owner_q;

   assign i_data_ok = complete && fetch_own && !flush_q && !flush_now;
   assign i_data    = i_data_ok ? (addr_q[2] ? m_data[63:32] : m_data[31:0]) : 32'd0;
   assign d_data_ok = complete && (owner_q == OWN_D);
   assign d_data    = d_data_ok ? m_data : 64'd0;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter: per-cycle vector table for the basic
// fetch/data/priority cases, then directed sequences for starvation, request
// stall, fetch redirect and reset during a transaction.
module tb_imem_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_valid = 1'b0;
   logic [63:0] i_addr = '0;
   logic        i_data_ok;
   logic [31:0] i_data;
   logic        d_valid = 1'b0;
   logic        d_write = 1'b0;
   logic [63:0] d_addr = '0;
   logic [2:0]  d_size = 3'd3;
   logic [7:0]  d_strobe = '0;
   logic [63:0] d_wdata = '0;
   logic        d_data_ok;
   logic [63:0] d_data;
   logic        m_valid;
   logic        m_write;
   logic [63:0] m_addr;
   logic [2:0]  m_size;
   logic [7:0]  m_strobe;
   logic [63:0] m_wdata;
   logic        m_ready = 1'b0;
   logic        m_data_ok = 1'b0;
   logic [63:0] m_data = '0;
   logic [1:0]  owner;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   imem_dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_data(i_data),
      .d_valid(d_valid), .d_write(d_write), .d_addr(d_addr), .d_size(d_size),
      .d_strobe(d_strobe), .d_wdata(d_wdata), .d_data_ok(d_data_ok), .d_data(d_data),
      .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_size(m_size),
      .m_strobe(m_strobe), .m_wdata(m_wdata), .m_ready(m_ready),
      .m_data_ok(m_data_ok), .m_data(m_data), .owner(owner)
   );

   typedef struct {
      string       nm;
      logic        rst;
      logic        iv;
      logic [63:0] ia;
      logic        dv;
      logic        dw;
      logic [63:0] da;
      logic [7:0]  ds;
      logic [63:0] dwd;
      logic        mr;
      logic        mok;
      logic [63:0] md;
      logic        all;    // compare memory-side fields even when m_valid=0
      logic        e_mv;
      logic        e_mw;
      logic [63:0] e_ma;
      logic [2:0]  e_msz;
      logic [7:0]  e_mstb;
      logic [63:0] e_mwd;
      logic [1:0]  e_own;
      logic        e_iok;
      logic [31:0] e_id;
      logic        e_dok;
      logic [63:0] e_dd;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl [NV];

   localparam logic [63:0] A1  = 64'h0000_0000_8000_0004;
   localparam logic [63:0] A2  = 64'h0000_0000_8000_0008;
   localparam logic [63:0] DA  = 64'h0000_0000_0000_1000;
   localparam logic [63:0] WD  = 64'h1122_3344_5566_7788;
   localparam logic [63:0] MD1 = 64'hDEAD_BEEF_0000_0013;
   localparam logic [63:0] MD2 = 64'hAAAA_BBBB_CCCC_DDDD;
   localparam logic [63:0] MD3 = 64'h9999_8888_1234_5678;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [240:0] act, input logic [240:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Start a new cycle: step past the active edge, then inputs may be driven.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      i_valid = 0; i_addr = '0; d_valid = 0; d_write = 0; d_addr = '0;
      d_strobe = '0; d_wdata = '0; m_ready = 0; m_data_ok = 0; m_data = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   initial begin
      logic [139:0] mact, mexp;
      logic [240:0] act, exp;

      //        name       rst iv A    dv dw da  ds     dwd mr mok md     all mv mw ma  msz mstb   mwd own iok id            dok dd
      tbl[0]  = '{"rst",    1, 0, 0,   0, 0, 0,  0,     0,  0, 0,  0,     1,  0, 0, 0,  0,  0,     0,  0,  0,  0,            0,  0};
      tbl[1]  = '{"idle",   0, 0, 0,   0, 0, 0,  0,     0,  0, 0,  0,     1,  0, 0, 0,  0,  0,     0,  0,  0,  0,            0,  0};
      tbl[2]  = '{"f_c0",   0, 1, A1,  0, 0, 0,  0,     0,  0, 0,  0,     0,  0, 0, 0,  0,  0,     0,  0,  0,  0,            0,  0};
      tbl[3]  = '{"f_req",  0, 1, A1,  0, 0, 0,  0,     0,  1, 0,  0,     0,  1, 0, A1, 2,  0,     0,  1,  0,  0,            0,  0};
      tbl[4]  = '{"f_wait", 0, 1, A1,  0, 0, 0,  0,     0,  0, 0,  0,     0,  0, 0, 0,  0,  0,     0,  1,  0,  0,            0,  0};
      tbl[5]  = '{"f_ok",   0, 1, A1,  0, 0, 0,  0,     0,  0, 1,  MD1,   0,  0, 0, 0,  0,  0,     0,  1,  1,  32'hDEADBEEF, 0,  0};
      tbl[6]  = '{"f_done", 0, 0, 0,   0, 0, 0,  0,     0,  0, 0,  0,     0,  0, 0, 0,  0,  0,     0,  0,  0,  0,            0,  0};
      tbl[7]  = '{"b_c0",   0, 1, A2,  1, 1, DA, 8'h0F, WD, 0, 0,  0,     0,  0, 0, 0,  0,  0,     0,  0,  0,  0,            0,  0};
      tbl[8]  = '{"b_dreq", 0, 1, A2,  1, 1, DA, 8'h0F, WD, 1, 0,  0,     0,  1, 1, DA, 3,  8'h0F, WD, 2,  0,  0,            0,  0};
      tbl[9]  = '{"b_dok",  0, 1, A2,  1, 1, DA, 8'h0F, WD, 0, 1,  MD2,   0,  0, 0, 0,  0,  0,     0,  2,  0,  0,            1,  MD2};
      tbl[10] = '{"b_idle", 0, 1, A2,  0, 0, 0,  0,     0,  0, 0,  0,     0,  0, 0, 0,  0,  0,     0,  0,  0,  0,            0,  0};
      tbl[11] = '{"b_freq", 0, 1, A2,  0, 0, 0,  0,     0,  1, 1,  MD3,   0,  1, 0, A2, 2,  0,     0,  1,  1,  32'h12345678, 0,  0};
      tbl[12] = '{"b_done", 0, 0, 0,   0, 0, 0,  0,     0,  0, 0,  0,     0,  0, 0, 0,  0,  0,     0,  0,  0,  0,            0,  0};
      tbl[13] = '{"idlemok",0, 0, 0,   0, 0, 0,  0,     0,  0, 1,  '1,    0,  0, 0, 0,  0,  0,     0,  0,  0,  0,            0,  0};

      for (int k = 0; k < NV; k++) begin
         cyc();
         reset = tbl[k].rst; i_valid = tbl[k].iv; i_addr = tbl[k].ia;
         d_valid = tbl[k].dv; d_write = tbl[k].dw; d_addr = tbl[k].da;
         d_strobe = tbl[k].ds; d_wdata = tbl[k].dwd;
         m_ready = tbl[k].mr; m_data_ok = tbl[k].mok; m_data = tbl[k].md;
         settle();
         mact = (tbl[k].all || tbl[k].e_mv) ? {m_write, m_addr, m_size, m_strobe, m_wdata} : '0;
         mexp = (tbl[k].all || tbl[k].e_mv) ?
                {tbl[k].e_mw, tbl[k].e_ma, tbl[k].e_msz, tbl[k].e_mstb, tbl[k].e_mwd} : '0;
         act = {m_valid, mact, owner, i_data_ok, i_data, d_data_ok, d_data};
         exp = {tbl[k].e_mv, mexp, tbl[k].e_own, tbl[k].e_iok, tbl[k].e_id, tbl[k].e_dok, tbl[k].e_dd};
         chkw(tbl[k].nm, act, exp);
      end

      // Starvation: both requesters stay valid; data wins 4 rounds, fetch the
      // 5th, then data again because the counter was cleared.
      cyc();
      clear_inputs();
      i_valid = 1; i_addr = 64'h8000_0010; d_valid = 1; d_addr = 64'h2000;
      for (int r = 0; r < 6; r++) begin
         settle();
         chk($sformatf("starve_r%0d_idle_owner", r), 64'(owner), 64'd0);
         cyc();
         m_ready = 1; m_data_ok = 0;
         settle();
         chk($sformatf("starve_r%0d_owner", r), 64'(owner), (r == 4) ? 64'd1 : 64'd2);
         chk($sformatf("starve_r%0d_mvalid", r), 64'(m_valid), 64'd1);
         cyc();
         m_ready = 0; m_data_ok = 1; m_data = 64'h5555_6666_7777_8888 + 64'(r);
         settle();
         chk($sformatf("starve_r%0d_iok", r), 64'(i_data_ok), (r == 4) ? 64'd1 : 64'd0);
         chk($sformatf("starve_r%0d_dok", r), 64'(d_data_ok), (r == 4) ? 64'd0 : 64'd1);
         if (r == 4) chk("starve_fetch_idata", 64'(i_data), 64'h7777_888C);
         cyc();
         m_data_ok = 0; m_data = '0;
      end
      clear_inputs();

      // Stall in REQ for 5 cycles; d_valid toggles and d_addr moves, m_* must not.
      cyc();
      d_valid = 1; d_write = 1; d_addr = 64'h3000; d_strobe = 8'hFF;
      d_wdata = 64'hCAFE_F00D_0123_4567;
      for (int c = 0; c < 5; c++) begin
         cyc();
         d_valid = (c % 2 == 1); d_addr = 64'h3000 + 64'((c + 1) * 8);
         m_ready = 0; m_data_ok = (c == 2);
         settle();
         chk($sformatf("stall%0d_mvalid", c), 64'(m_valid), 64'd1);
         chk($sformatf("stall%0d_maddr", c), m_addr, 64'h3000);
         chk($sformatf("stall%0d_mwdata", c), m_wdata, 64'hCAFE_F00D_0123_4567);
         chk($sformatf("stall%0d_dok", c), 64'(d_data_ok), 64'd0);
      end
      cyc();
      m_ready = 1; m_data_ok = 0;
      settle();
      chk("stall_accept_mvalid", 64'(m_valid), 64'd1);
      cyc();
      m_ready = 0; d_valid = 0; d_addr = '0; m_data_ok = 1; m_data = 64'h0BAD_CAFE_0000_0001;
      settle();
      chk("stall_withdrawn_dok", 64'(d_data_ok), 64'd1);
      chk("stall_ddata", d_data, 64'h0BAD_CAFE_0000_0001);
      chk("stall_iok_quiet", 64'(i_data_ok), 64'd0);
      cyc();
      clear_inputs();

      // Fetch redirect during WAIT: response is drained, new address follows.
      i_valid = 1; i_addr = 64'h8000_0000;
      cyc();
      m_ready = 1;
      settle();
      chk("redir_maddr0", m_addr, 64'h8000_0000);
      cyc();
      m_ready = 0; i_addr = 64'h8000_0100;
      settle();
      chk("redir_wait_iok", 64'(i_data_ok), 64'd0);
      cyc();
      // Address back to the original: only the remembered flush can suppress.
      i_addr = 64'h8000_0000; m_data_ok = 1; m_data = 64'h1111_2222_3333_4444;
      settle();
      chk("redir_drained_iok", 64'(i_data_ok), 64'd0);
      chk("redir_drained_idata", 64'(i_data), 64'd0);
      chk("redir_drained_dok", 64'(d_data_ok), 64'd0);
      cyc();
      m_data_ok = 0; i_addr = 64'h8000_0100;
      settle();
      chk("redir_idle_owner", 64'(owner), 64'd0);
      cyc();
      m_ready = 1;
      settle();
      chk("redir_new_maddr", m_addr, 64'h8000_0100);
      chk("redir_new_mvalid", 64'(m_valid), 64'd1);
      cyc();
      m_ready = 0; m_data_ok = 1;
      settle();
      chk("redir_new_iok", 64'(i_data_ok), 64'd1);
      chk("redir_new_idata", 64'(i_data), 64'h3333_4444);
      cyc();
      // Fetch drops exactly in the completion cycle.
      m_data_ok = 0; i_addr = 64'h8000_0204;
      cyc();
      m_ready = 1;
      settle();
      chk("drop_owner", 64'(owner), 64'd1);
      cyc();
      m_ready = 0; i_valid = 0; m_data_ok = 1; m_data = 64'h7777_7777_7777_7777;
      settle();
      chk("drop_iok", 64'(i_data_ok), 64'd0);
      cyc();
      clear_inputs();

      // Reset while data owns the port in WAIT.
      d_valid = 1; d_addr = 64'h4000; d_write = 0; d_strobe = 0;
      cyc();
      m_ready = 1;
      settle();
      chk("rstw_req_mvalid", 64'(m_valid), 64'd1);
      cyc();
      m_ready = 0; reset = 1;
      cyc();
      reset = 0; d_valid = 0; m_data_ok = 1; m_data = 64'hFFFF_0000_FFFF_0000;
      settle();
      chk("rstw_owner", 64'(owner), 64'd0);
      chk("rstw_mvalid", 64'(m_valid), 64'd0);
      chk("rstw_maddr", m_addr, 64'd0);
      chk("rstw_dok", 64'(d_data_ok), 64'd0);
      chk("rstw_ddata", d_data, 64'd0);
      chk("rstw_iok", 64'(i_data_ok), 64'd0);
      cyc();
      settle();
      chk("rstw_late_dok", 64'(d_data_ok), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
